// File: rtl/apb_wb_irq_bridge.sv
// APB slave with local interrupt registers (RIS/IM/MIS/ICR/EDGE) and a bridge to a 16-bit Wishbone master.
// Define APB_WB_IRQ_BRIDGE_TIMEOUT_EN to add the Wishbone ack timeout; dbg_state exposes the bridge FSM.
module apb_wb_irq_bridge #(
  parameter int          NUM_FLAGS      = 9,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [7:0]  LOCAL_PAGE     = 8'h0F
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [15:0]          PADDR,
  input  logic [31:0]          PWDATA,
  output logic                 PREADY,
  output logic [31:0]          PRDATA,
  output logic                 PSLVERR,
  output logic [2:0]           wbs_adr_o,
  output logic [15:0]          wbs_dat_o,
  input  logic [15:0]          wbs_dat_i,
  output logic                 wbs_we_o,
  output logic                 wbs_stb_o,
  output logic                 wbs_cyc_o,
  input  logic                 wbs_ack_i,
  input  logic [NUM_FLAGS-1:0] flags_i,
  output logic                 irq,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [7:0] OFF_RIS  = 8'h00;
  localparam logic [7:0] OFF_IM   = 8'h04;
  localparam logic [7:0] OFF_MIS  = 8'h08;
  localparam logic [7:0] OFF_ICR  = 8'h0C;
  localparam logic [7:0] OFF_EDGE = 8'h10;

  // Handshakes: an APB transfer completes on the edge where PSEL&PENABLE&PREADY are all high;
  // a Wishbone cycle completes on the edge where wbs_cyc_o&wbs_stb_o&wbs_ack_i are all high,
  // and the master holds adr/dat/we steady for as long as cyc/stb stay up.

  logic                 is_local;
  logic                 local_acc;
  logic                 local_wr;
  logic                 off_hit;
  logic [31:0]          local_rdata;
  logic [NUM_FLAGS-1:0] flags_q;
  logic [NUM_FLAGS-1:0] sticky;
  logic [NUM_FLAGS-1:0] im;
  logic [NUM_FLAGS-1:0] edge_en;
  logic [NUM_FLAGS-1:0] rise;
  logic [NUM_FLAGS-1:0] ris;
  logic [NUM_FLAGS-1:0] mis;
  logic [NUM_FLAGS-1:0] icr_clr;
  logic [1:0]           state;
  logic [15:0]          rdata;
  logic                 err;
  logic                 unused_pwdata;

  assign is_local  = (PADDR[15:8] == LOCAL_PAGE);
  assign local_acc = PSEL & PENABLE & is_local;
  assign local_wr  = local_acc & PWRITE;
  assign dbg_state = state;
  assign unused_pwdata = ^PWDATA;

  assign rise    = flags_i & ~flags_q;
  assign ris     = (edge_en & sticky) | (~edge_en & flags_i);
  assign mis     = ris & im;
  assign icr_clr = (local_wr && PADDR[7:0] == OFF_ICR) ? PWDATA[NUM_FLAGS-1:0] : '0;

  always_comb begin
    local_rdata = 32'h0;
    off_hit     = 1'b1;
    case (PADDR[7:0])
      OFF_RIS:  local_rdata = 32'(ris);
      OFF_IM:   local_rdata = 32'(im);
      OFF_MIS:  local_rdata = 32'(mis);
      OFF_ICR:  local_rdata = 32'h0;
      OFF_EDGE: local_rdata = 32'(edge_en);
      default: begin
        local_rdata = 32'hDEADBEEF;
        off_hit     = 1'b0;
      end
    endcase
  end

  always_comb begin
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    PRDATA  = 32'h0;
    if (PRESETn) begin
      if (state == ST_RESP) begin
        PREADY  = 1'b1;
        PSLVERR = err;
        PRDATA  = (wbs_we_o || err) ? 32'h0 : {16'h0, rdata};
      end else if (local_acc) begin
        PREADY  = 1'b1;
        PSLVERR = ~off_hit;
        PRDATA  = local_rdata;
      end
    end
  end

  // A rise on the same edge as an ICR clear wins, so no edge event is lost.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      flags_q <= '0;
      sticky  <= '0;
      im      <= '0;
      edge_en <= '0;
      irq     <= 1'b0;
    end else begin
      flags_q <= flags_i;
      sticky  <= (sticky & ~icr_clr) | rise;
      irq     <= |mis;
      if (local_wr && PADDR[7:0] == OFF_IM)   im      <= PWDATA[NUM_FLAGS-1:0];
      if (local_wr && PADDR[7:0] == OFF_EDGE) edge_en <= PWDATA[NUM_FLAGS-1:0];
    end
  end

`ifdef APB_WB_IRQ_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
  logic [15:0] tcnt;
  logic [15:0] tcnt_next;
  assign tcnt_next = tcnt + 16'd1;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      wbs_cyc_o <= 1'b0;
      wbs_stb_o <= 1'b0;
      wbs_we_o  <= 1'b0;
      wbs_adr_o <= 3'd0;
      wbs_dat_o <= 16'h0;
      rdata     <= 16'h0;
      err       <= 1'b0;
`ifdef APB_WB_IRQ_BRIDGE_TIMEOUT_EN
      tcnt      <= 16'h0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (PSEL && !PENABLE && !is_local) begin
            wbs_adr_o <= PADDR[3:1];
            wbs_dat_o <= PWDATA[15:0];
            wbs_we_o  <= PWRITE;
            wbs_cyc_o <= 1'b1;
            wbs_stb_o <= 1'b1;
            err       <= 1'b0;
`ifdef APB_WB_IRQ_BRIDGE_TIMEOUT_EN
            tcnt      <= 16'h0;
`endif
            state     <= ST_BUS;
          end
        end
        ST_BUS: begin
          if (wbs_ack_i) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            rdata     <= wbs_dat_i;
            state     <= ST_RESP;
`ifdef APB_WB_IRQ_BRIDGE_TIMEOUT_EN
          end else if (tcnt_next == TO_LIMIT) begin
            wbs_cyc_o <= 1'b0;
            wbs_stb_o <= 1'b0;
            err       <= 1'b1;
            state     <= ST_RESP;
          end else begin
            tcnt      <= tcnt_next;
`endif
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_wb_irq_bridge.sv
// Directed bench for apb_wb_irq_bridge: APB driver tasks, a Wishbone slave responder,
// and a response scoreboard keyed by an expected queue.
module tb_apb_wb_irq_bridge;

  localparam int NF = 9;

  logic          PCLK;
  logic          PRESETn;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [15:0]   PADDR;
  logic [31:0]   PWDATA;
  logic          PREADY;
  logic [31:0]   PRDATA;
  logic          PSLVERR;
  logic [2:0]    wbs_adr_o;
  logic [15:0]   wbs_dat_o;
  logic [15:0]   wbs_dat_i = 16'h0;
  logic          wbs_we_o;
  logic          wbs_stb_o;
  logic          wbs_cyc_o;
  logic          wbs_ack_i;
  logic [NF-1:0] flags_i;
  logic          irq;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int waited_n;
  logic [32:0] exp_q[$];
  logic [32:0] msk_q[$];

  int          ack_delay = 0;
  logic [15:0] slave_data = 16'h0;
  logic        ack_model = 1'b0;
  logic        spurious_ack = 1'b0;
  int          wb_cnt = 0;
  logic [2:0]  cap_adr = 3'd0;
  logic [15:0] cap_dat = 16'h0;
  logic        cap_we = 1'b0;
  int          unstable = 0;

  assign wbs_ack_i = ack_model | spurious_ack;

  apb_wb_irq_bridge #(
    .NUM_FLAGS(NF),
    .TIMEOUT_CYCLES(4),
    .LOCAL_PAGE(8'h0F)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_dat_i(wbs_dat_i),
    .wbs_we_o(wbs_we_o), .wbs_stb_o(wbs_stb_o), .wbs_cyc_o(wbs_cyc_o),
    .wbs_ack_i(wbs_ack_i),
    .flags_i(flags_i), .irq(irq), .dbg_state(dbg_state)
  );

  // Clock
  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Wishbone slave: acks ack_delay cycles into a cycle (0 = never), records and tracks address/data/we.
  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ack_model <= 1'b0;
      wb_cnt    <= 0;
    end else begin
      ack_model <= 1'b0;
      if (wbs_cyc_o && wbs_stb_o && !ack_model) begin
        if (wb_cnt == 0) begin
          cap_adr <= wbs_adr_o;
          cap_dat <= wbs_dat_o;
          cap_we  <= wbs_we_o;
        end else if ({wbs_adr_o, wbs_dat_o, wbs_we_o} !== {cap_adr, cap_dat, cap_we}) begin
          unstable <= unstable + 1;
        end
        if (ack_delay != 0 && wb_cnt + 1 >= ack_delay) begin
          ack_model <= 1'b1;
          wbs_dat_i <= slave_data;
          wb_cnt    <= 0;
        end else begin
          wb_cnt <= wb_cnt + 1;
        end
      end else begin
        wb_cnt <= 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                          input logic [NF-1:0] pulse, input logic [32:0] exp, input logic [32:0] msk,
                          input string tag, output int waited);
    logic [32:0] e;
    logic [32:0] m;
    logic        done;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    exp_q.push_back(exp);
    msk_q.push_back(msk);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    flags_i = flags_i | pulse;
    waited = 0;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge PCLK);
      waited++;
      if (PREADY) done = 1'b1;
    end
    e = exp_q.pop_front();
    m = msk_q.pop_front();
    check({tag, "_ready"}, 64'(done), 64'd1);
    check(tag, 64'({PSLVERR, PRDATA} & m), 64'(e & m));
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    flags_i = flags_i & ~pulse;
    @(negedge PCLK);
    check({tag, "_idle"}, 64'(PREADY), 64'd0);
  endtask

  task automatic lwr(input logic [15:0] addr, input logic [31:0] data, input string tag);
    int w;
    apb_xfer(1'b1, addr, data, '0, 33'h0, 33'h1_0000_0000, tag, w);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [31:0] exp_data, input logic exp_err,
                    input string tag, output int waited);
    apb_xfer(1'b0, addr, 32'h0, '0, {exp_err, exp_data}, {33{1'b1}}, tag, waited);
  endtask

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 16'h0; PWDATA = 32'h0; flags_i = '0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_pready", 64'(PREADY), 64'd0);
    check("rst_pslverr", 64'(PSLVERR), 64'd0);
    check("rst_wb", 64'({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_adr_o, wbs_dat_o}), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;

    rd(16'h0F04, 32'h0, 1'b0, "im_rst", waited_n);
    check("local_wait", 64'(waited_n), 64'd1);
    rd(16'h0F10, 32'h0, 1'b0, "edge_rst", waited_n);
    rd(16'h0F00, 32'h0, 1'b0, "ris_rst", waited_n);

    // Edge-mode pulse, latency of irq, ICR clear
    lwr(16'h0F04, 32'h1FF, "wr_im");
    lwr(16'h0F10, 32'h001, "wr_edge");
    rd(16'h0F10, 32'h001, 1'b0, "edge_rd", waited_n);
    @(posedge PCLK); #1; flags_i[0] = 1'b1;
    @(posedge PCLK); #1; flags_i[0] = 1'b0;
    @(negedge PCLK);
    check("irq_lat0", 64'(irq), 64'd0);
    @(negedge PCLK);
    check("irq_pulse", 64'(irq), 64'd1);
    rd(16'h0F00, 32'h001, 1'b0, "ris_edge", waited_n);
    rd(16'h0F08, 32'h001, 1'b0, "mis_edge", waited_n);
    rd(16'h0F0C, 32'h0, 1'b0, "icr_reads0", waited_n);
    lwr(16'h0F0C, 32'h001, "icr_clr");
    rd(16'h0F00, 32'h0, 1'b0, "ris_cleared", waited_n);
    check("irq_cleared", 64'(irq), 64'd0);

    // Level mode on flag 3
    lwr(16'h0F04, 32'h0, "im_zero");
    lwr(16'h0F10, 32'h0, "edge_zero");
    @(posedge PCLK); #1; flags_i[3] = 1'b1;
    rd(16'h0F00, 32'h008, 1'b0, "ris_level", waited_n);
    rd(16'h0F08, 32'h0, 1'b0, "mis_masked", waited_n);
    check("irq_masked", 64'(irq), 64'd0);
    lwr(16'h0F04, 32'h008, "im_b3");
    repeat (2) @(negedge PCLK);
    check("irq_level", 64'(irq), 64'd1);
    @(posedge PCLK); #1; flags_i[3] = 1'b0;
    rd(16'h0F00, 32'h0, 1'b0, "ris_level_off", waited_n);
    repeat (2) @(negedge PCLK);
    check("irq_level_off", 64'(irq), 64'd0);

    // Rise coinciding with ICR clear keeps sticky set
    lwr(16'h0F10, 32'h001, "edge_b0");
    lwr(16'h0F0C, 32'h1FF, "icr_all");
    rd(16'h0F00, 32'h0, 1'b0, "ris_pre_race", waited_n);
    apb_xfer(1'b1, 16'h0F0C, 32'h001, 9'h001, 33'h0, 33'h1_0000_0000, "icr_vs_rise", waited_n);
    rd(16'h0F00, 32'h001, 1'b0, "sticky_kept", waited_n);
    lwr(16'h0F0C, 32'h001, "icr_after_race");
    rd(16'h0F00, 32'h0, 1'b0, "ris_post_race", waited_n);

    // Unmapped local offsets
    rd(16'h0F20, 32'hDEADBEEF, 1'b1, "unmapped_rd", waited_n);
    apb_xfer(1'b1, 16'h0F14, 32'h1FF, '0, {1'b1, 32'hDEADBEEF}, {33{1'b1}}, "unmapped_wr", waited_n);
    rd(16'h0F04, 32'h008, 1'b0, "im_after_unmapped", waited_n);

    // Spurious ack while idle
    @(posedge PCLK); #1; spurious_ack = 1'b1;
    @(posedge PCLK); #1; spurious_ack = 1'b0;
    @(negedge PCLK);
    check("spurious_state", 64'(dbg_state), 64'd0);
    check("spurious_cyc", 64'({wbs_cyc_o, wbs_stb_o}), 64'd0);

    // Wishbone read, write, and another read
    ack_delay = 2; slave_data = 16'hA5C3;
    rd(16'h0002, 32'h0000A5C3, 1'b0, "wb_rd", waited_n);
    check("wb_rd_wait", 64'(waited_n), 64'd4);
    check("wb_rd_adr", 64'(cap_adr), 64'd1);
    check("wb_rd_we", 64'(cap_we), 64'd0);
    ack_delay = 1;
    apb_xfer(1'b1, 16'h0006, 32'hABCD1234, '0, 33'h0, {33{1'b1}}, "wb_wr", waited_n);
    check("wb_wr_wait", 64'(waited_n), 64'd3);
    check("wb_wr_adr", 64'(cap_adr), 64'd3);
    check("wb_wr_dat", 64'(cap_dat), 64'h1234);
    check("wb_wr_we", 64'(cap_we), 64'd1);
    ack_delay = 3; slave_data = 16'h5A5A;
    rd(16'h100E, 32'h00005A5A, 1'b0, "wb_rd2", waited_n);
    check("wb_rd2_wait", 64'(waited_n), 64'd5);
    check("wb_rd2_adr", 64'(cap_adr), 64'd7);

    // Slave that does not answer
    ack_delay = 0; slave_data = 16'hBEEF;
`ifdef APB_WB_IRQ_BRIDGE_TIMEOUT_EN
    rd(16'h0004, 32'h0, 1'b1, "wb_timeout", waited_n);
    check("wb_timeout_wait", 64'(waited_n), 64'd5);
`else
    fork
      rd(16'h0004, 32'h0000BEEF, 1'b0, "wb_hold", waited_n);
      begin
        repeat (20) @(negedge PCLK);
        check("wb_hold_cyc", 64'({wbs_cyc_o, wbs_stb_o}), 64'd3);
        check("wb_hold_pready", 64'(PREADY), 64'd0);
        ack_delay = 1;
      end
    join
`endif
    check("wb_stable", 64'(unstable), 64'd0);

    // Reset in the middle of a Wishbone cycle
    lwr(16'h0F04, 32'h1FF, "im_all");
    @(posedge PCLK); #1; flags_i[1] = 1'b1;
    repeat (3) @(negedge PCLK);
    check("irq_pre_rst", 64'(irq), 64'd1);
    ack_delay = 0;
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 16'h0008;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (3) @(posedge PCLK);
    #2;
    check("cyc_pre_rst", 64'({wbs_cyc_o, wbs_stb_o}), 64'd3);
    PRESETn = 1'b0;
    #1;
    check("rst_mid_cyc", 64'({wbs_cyc_o, wbs_stb_o}), 64'd0);
    check("rst_mid_pready", 64'({PREADY, PSLVERR}), 64'd0);
    check("rst_mid_state", 64'(dbg_state), 64'd0);
    check("rst_mid_irq", 64'(irq), 64'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    rd(16'h0F04, 32'h0, 1'b0, "im_post_rst", waited_n);
    check("irq_post_rst", 64'(irq), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
